// File: rtl/imem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// imem_ctrl_pkg
//   Shared definitions for the instruction-memory load controller.
//   Contents:
//     ADDR_W_DEF / DATA_W_DEF : default memory geometry
//     ZERO_WORD               : all-zero word (NOP/clear pattern)
//     state_e                 : controller state encoding
//     is_busy()               : true while a load sequence is in flight
// ----------------------------------------------------------------------------
package imem_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [63:0] ZERO_WORD = 64'h0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_CLEAR) || (s == ST_LOAD) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/imem_ld_counter.sv
// ----------------------------------------------------------------------------
// imem_ld_counter
//   Saturating write-address counter plus accepted-word counter.
//   Ports:
//     clock   in   system clock, rising edge
//     reset   in   asynchronous active-high reset
//     init    in   reload address with START_ADDR and clear the word count
//     inc     in   one word accepted: advance address and count
//     addr    out  [ADDR_W]   current write address
//     count   out  [ADDR_W+1] words accepted since the last init
//     at_max  out  address sits at the top of memory; another increment
//                  would wrap, so the address holds instead
// ----------------------------------------------------------------------------
module imem_ld_counter #(
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              at_max
);

  localparam logic [ADDR_W-1:0] START_VAL = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] MAX_ADDR  = '1;
  localparam logic [ADDR_W:0]   MAX_COUNT = '1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  assign at_max = (addr_q == MAX_ADDR);

  // init wins over inc; both counters saturate rather than wrap.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (init) begin
      addr_d  = START_VAL;
      count_d = '0;
    end else if (inc) begin
      if (!at_max) begin
        addr_d = addr_q + 1'b1;
      end
      if (count_q != MAX_COUNT) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= START_VAL;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign addr  = addr_q;
  assign count = count_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// ----------------------------------------------------------------------------
// imem_load_ctrl
//   Loads a program into instruction memory over a valid/ready stream, then
//   releases the core from reset.
//   Build option: define IMEM_LOAD_CLEAR_EN to zero-fill the whole memory
//   (CLEAR state) before each load; otherwise start goes straight to LOAD.
//   Ports:
//     clock       in   system clock, rising edge
//     reset       in   asynchronous active-high reset
//     start       in   single-cycle load request (honoured in IDLE and RUN)
//     load_valid  in   load_data valid
//     load_data   in   [DATA_W] instruction word
//     load_last   in   final word of the program
//     load_ready  out  word accepted this cycle (LOAD state)
//     imem_we     out  memory write strobe
//     imem_addr   out  [ADDR_W] write address
//     imem_wdata  out  [DATA_W] write data
//     rw          out  0 = write/load, 1 = read/fetch
//     core_reset  out  pipeline reset, active-high
//     busy        out  CLEAR, LOAD or RELEASE
//     done        out  program loaded, core running
//     error       out  sticky address-overflow flag
//     word_count  out  [ADDR_W+1] words accepted in the current load
// ----------------------------------------------------------------------------
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int START_ADDR     = 1,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              rw,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [3:0]        REL_LAST = 4'(RELEASE_CYCLES - 1);
  localparam logic [DATA_W-1:0] ZERO_W   = DATA_W'(ZERO_WORD);

  state_e            state_q, state_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              error_q, error_d;
  logic [3:0]        rel_cnt_q, rel_cnt_d;

  logic              cnt_init;
  logic              cnt_inc;
  logic [ADDR_W-1:0] cnt_addr;
  logic [ADDR_W:0]   cnt_count;
  logic              cnt_at_max;
  logic              handshake;

`ifdef IMEM_LOAD_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;
  localparam state_e            FIRST_ST = ST_CLEAR;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clearing;
`else
  localparam state_e            FIRST_ST = ST_LOAD;
`endif

  imem_ld_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .init   (cnt_init),
    .inc    (cnt_inc),
    .addr   (cnt_addr),
    .count  (cnt_count),
    .at_max (cnt_at_max)
  );

  assign load_ready = (state_q == ST_LOAD);
  assign handshake  = load_valid && load_ready;

  // Next-state logic. Accepted words are registered and written one cycle
  // later, so the final write of a load is still on the bus in the first
  // RELEASE cycle; the release countdown only runs once that write drains,
  // which keeps imem_we and rw=1 mutually exclusive.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    error_d      = error_q;
    rel_cnt_d    = rel_cnt_q;
    cnt_init     = 1'b0;
    cnt_inc      = 1'b0;
`ifdef IMEM_LOAD_CLEAR_EN
    clr_addr_d   = clr_addr_q;
`endif

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          state_d  = FIRST_ST;
          cnt_init = 1'b1;
          error_d  = 1'b0;
`ifdef IMEM_LOAD_CLEAR_EN
          clr_addr_d = '0;
`endif
        end
      end

`ifdef IMEM_LOAD_CLEAR_EN
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == CLR_LAST) begin
          state_d = ST_LOAD;
        end
      end
`endif

      ST_LOAD: begin
        if (handshake) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = cnt_addr;
          imem_wdata_d = load_data;
          cnt_inc      = 1'b1;
          rel_cnt_d    = '0;
          if (load_last) begin
            state_d = ST_RELEASE;
          end else if (cnt_at_max) begin
            // Memory full with no end-of-program marker: stop, flag it.
            error_d = 1'b1;
            state_d = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        if (!imem_we_q) begin
          if (rel_cnt_q == REL_LAST) begin
            state_d = ST_RUN;
          end else begin
            rel_cnt_d = rel_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      error_q      <= 1'b0;
      rel_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      error_q      <= error_d;
      rel_cnt_q    <= rel_cnt_d;
    end
  end

`ifdef IMEM_LOAD_CLEAR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_addr_q <= '0;
    end else begin
      clr_addr_q <= clr_addr_d;
    end
  end

  // Clear writes go straight out from the sweep counter so that every
  // zero write lands before load_ready rises.
  assign clearing   = (state_q == ST_CLEAR);
  assign imem_we    = imem_we_q | clearing;
  assign imem_addr  = clearing ? clr_addr_q : imem_addr_q;
  assign imem_wdata = clearing ? ZERO_W : imem_wdata_q;
`else
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
`endif

  assign rw         = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !imem_we_q;
  assign core_reset = (state_q != ST_RUN);
  assign busy       = is_busy(state_q);
  assign done       = (state_q == ST_RUN);
  assign error      = error_q;
  assign word_count = cnt_count;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_load_ctrl
//   Directed bench for imem_load_ctrl: one default instance, one instance
//   placed near the top of memory, and (with IMEM_LOAD_CLEAR_EN) a small
//   instance for the zero-fill sweep.
// ----------------------------------------------------------------------------
module tb_imem_load_ctrl;

  logic        clock;
  logic        reset;

  // default instance
  logic        start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready, imem_we, rw, core_reset, busy, done, error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_count;

  // instance with START_ADDR near the top
  logic        start_h, valid_h, last_h;
  logic [31:0] data_h;
  logic        ready_h, we_h, rw_h, core_reset_h, busy_h, done_h, error_h;
  logic [9:0]  addr_h;
  logic [31:0] wdata_h;
  logic [10:0] count_h;

  int total_checks;
  int bad_checks;

  imem_load_ctrl u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .rw         (rw),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  imem_load_ctrl #(.START_ADDR(1022)) u_dut_hi (
    .clock      (clock),
    .reset      (reset),
    .start      (start_h),
    .load_valid (valid_h),
    .load_data  (data_h),
    .load_last  (last_h),
    .load_ready (ready_h),
    .imem_we    (we_h),
    .imem_addr  (addr_h),
    .imem_wdata (wdata_h),
    .rw         (rw_h),
    .core_reset (core_reset_h),
    .busy       (busy_h),
    .done       (done_h),
    .error      (error_h),
    .word_count (count_h)
  );

`ifdef IMEM_LOAD_CLEAR_EN
  logic        start_c;
  logic        ready_c, we_c, rw_c, core_reset_c, busy_c, done_c, error_c;
  logic [3:0]  addr_c;
  logic [31:0] wdata_c;
  logic [4:0]  count_c;

  imem_load_ctrl #(.ADDR_W(4)) u_dut_clr (
    .clock      (clock),
    .reset      (reset),
    .start      (start_c),
    .load_valid (1'b0),
    .load_data  (32'h0),
    .load_last  (1'b0),
    .load_ready (ready_c),
    .imem_we    (we_c),
    .imem_addr  (addr_c),
    .imem_wdata (wdata_c),
    .rw         (rw_c),
    .core_reset (core_reset_c),
    .busy       (busy_c),
    .done       (done_c),
    .error      (error_c),
    .word_count (count_c)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic last);
    load_valid = valid;
    load_data  = data;
    load_last  = last;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic waitReady();
    for (int k = 0; k < 2000 && !load_ready; k++) step();
    checkOutput("ready_up", 64'(load_ready), 64'd1);
  endtask

  task automatic waitDone();
    for (int k = 0; k < 50 && !done; k++) step();
    checkOutput("done_up", 64'(done), 64'd1);
  endtask

  logic [31:0] words1 [3];
  logic [31:0] words2 [4];

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    words1 = '{32'h00102083, 32'h00250183, 32'h003080B3};
    words2 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    reset = 1'b0;
    start = 1'b0;
    start_h = 1'b0; valid_h = 1'b0; data_h = '0; last_h = 1'b0;
`ifdef IMEM_LOAD_CLEAR_EN
    start_c = 1'b0;
`endif
    applyStimulus(1'b0, 32'h0, 1'b0);

    // reset values
    #2 reset = 1'b1;
    #2;
    checkOutput("rst_core_reset", 64'(core_reset), 64'd1);
    checkOutput("rst_rw",         64'(rw),         64'd0);
    checkOutput("rst_we",         64'(imem_we),    64'd0);
    checkOutput("rst_addr",       64'(imem_addr),  64'd0);
    checkOutput("rst_wdata",      64'(imem_wdata), 64'd0);
    checkOutput("rst_ready",      64'(load_ready), 64'd0);
    checkOutput("rst_busy",       64'(busy),       64'd0);
    checkOutput("rst_done",       64'(done),       64'd0);
    checkOutput("rst_error",      64'(error),      64'd0);
    checkOutput("rst_count",      64'(word_count), 64'd0);
    step();
    reset = 1'b0;
    step();
    checkOutput("idle_busy", 64'(busy), 64'd0);

    // first program: three back-to-back words
    pulseStart();
    checkOutput("start_busy", 64'(busy),       64'd1);
    checkOutput("start_core", 64'(core_reset), 64'd1);
    checkOutput("start_rw",   64'(rw),         64'd0);
    waitReady();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, words1[i], i == 2);
      step();
      checkOutput("p1_we",    64'(imem_we),    64'd1);
      checkOutput("p1_addr",  64'(imem_addr),  64'(1 + i));
      checkOutput("p1_wdata", 64'(imem_wdata), 64'(words1[i]));
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("p1_ready_low", 64'(load_ready), 64'd0);
    checkOutput("p1_count",     64'(word_count), 64'd3);
    checkOutput("p1_rel0_core", 64'(core_reset), 64'd1);
    step();
    checkOutput("p1_rel1_rw",   64'(rw),         64'd1);
    checkOutput("p1_rel1_core", 64'(core_reset), 64'd1);
    checkOutput("p1_rel1_we",   64'(imem_we),    64'd0);
    step();
    checkOutput("p1_rel2_core", 64'(core_reset), 64'd1);
    checkOutput("p1_rel2_done", 64'(done),       64'd0);
    step();
    checkOutput("p1_run_core", 64'(core_reset), 64'd0);
    checkOutput("p1_run_done", 64'(done),       64'd1);
    checkOutput("p1_run_rw",   64'(rw),         64'd1);
    checkOutput("p1_run_busy", 64'(busy),       64'd0);

    // restart from RUN; load_valid toggles every other cycle
    pulseStart();
    checkOutput("rs_core",  64'(core_reset), 64'd1);
    checkOutput("rs_rw",    64'(rw),         64'd0);
    checkOutput("rs_done",  64'(done),       64'd0);
    checkOutput("rs_count", 64'(word_count), 64'd0);
    waitReady();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, words2[i], i == 3);
      step();
      checkOutput("p2_we",    64'(imem_we),    64'd1);
      checkOutput("p2_addr",  64'(imem_addr),  64'(1 + i));
      checkOutput("p2_wdata", 64'(imem_wdata), 64'(words2[i]));
      applyStimulus(1'b0, 32'h0, 1'b0);
      step();
      checkOutput("p2_gap_we", 64'(imem_we), 64'd0);
    end
    checkOutput("p2_count", 64'(word_count), 64'd4);
    waitDone();

    // reset in the middle of a load, with a second handshake on the way
    pulseStart();
    waitReady();
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
    step();
    checkOutput("mid_we_before", 64'(imem_we), 64'd1);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_we",    64'(imem_we),    64'd0);
    checkOutput("mid_busy",  64'(busy),       64'd0);
    checkOutput("mid_ready", 64'(load_ready), 64'd0);
    checkOutput("mid_core",  64'(core_reset), 64'd1);
    checkOutput("mid_count", 64'(word_count), 64'd0);
    checkOutput("mid_addr",  64'(imem_addr),  64'd0);
    step();
    checkOutput("mid_we_edge", 64'(imem_we), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    step();
    checkOutput("mid_after_we",   64'(imem_we), 64'd0);
    checkOutput("mid_after_busy", 64'(busy),    64'd0);

    // overflow at the top of memory without load_last
    start_h = 1'b1;
    step();
    start_h = 1'b0;
    for (int k = 0; k < 2000 && !ready_h; k++) step();
    checkOutput("hi_ready_up", 64'(ready_h), 64'd1);
    valid_h = 1'b1;
    data_h  = 32'hA0A0A0A0;
    step();
    checkOutput("hi_w0_we",   64'(we_h),   64'd1);
    checkOutput("hi_w0_addr", 64'(addr_h), 64'd1022);
    data_h = 32'hB1B1B1B1;
    step();
    checkOutput("hi_w1_we",    64'(we_h),    64'd1);
    checkOutput("hi_w1_addr",  64'(addr_h),  64'd1023);
    checkOutput("hi_w1_data",  64'(wdata_h), 64'hB1B1B1B1);
    checkOutput("hi_error",    64'(error_h), 64'd1);
    checkOutput("hi_ready_lo", 64'(ready_h), 64'd0);
    checkOutput("hi_count",    64'(count_h), 64'd2);
    data_h = 32'hC2C2C2C2;
    step();
    checkOutput("hi_w2_we",    64'(we_h),    64'd0);
    checkOutput("hi_w2_count", 64'(count_h), 64'd2);
    valid_h = 1'b0;
    for (int k = 0; k < 50 && !done_h; k++) step();
    checkOutput("hi_done",       64'(done_h),  64'd1);
    checkOutput("hi_error_keep", 64'(error_h), 64'd1);
    checkOutput("hi_addr_hold",  64'(addr_h),  64'd1023);

`ifdef IMEM_LOAD_CLEAR_EN
    begin
      int zero_writes;
      zero_writes = 0;
      start_c = 1'b1;
      step();
      start_c = 1'b0;
      for (int k = 0; k < 100 && !ready_c; k++) begin
        if (we_c && wdata_c == 32'h0 && 32'(addr_c) == zero_writes) zero_writes++;
        step();
      end
      checkOutput("clr_writes", 64'(zero_writes), 64'd16);
      checkOutput("clr_ready",  64'(ready_c),     64'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the instruction-memory address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter START_ADDR, default 1, SHALL set the first address written in a load.
REQ-004 Parameter RELEASE_CYCLES, default 2 (range 1..15), SHALL set the number of cycles core_reset is held after loading.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clock  in  1  system clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high block reset.
REQ-008 start  in  1  single-cycle request to begin a program load.
REQ-009 load_valid  in  1  load_data is valid this cycle.
REQ-010 load_data  in  DATA_W  instruction word to store.
REQ-011 load_last  in  1  qualifies the final word of the program.
REQ-012 load_ready  out  1  block accepts a word this cycle.
REQ-013 imem_we  out  1  instruction-memory write strobe.
REQ-014 imem_addr  out  ADDR_W  write address (PC_write on the memory side).
REQ-015 imem_wdata  out  DATA_W  write data.
REQ-016 rw  out  1  memory mode: 0 = write/load, 1 = read/fetch.
REQ-017 core_reset  out  1  pipeline reset, active-high.
REQ-018 busy  out  1  state is CLEAR, LOAD or RELEASE.
REQ-019 done  out  1  program loaded and core running.
REQ-020 error  out  1  sticky address-overflow flag.
REQ-021 word_count  out  ADDR_W+1  number of words accepted in the current load.

Function
REQ-022 The states SHALL be IDLE, CLEAR, LOAD, RELEASE and RUN.
REQ-023 IDLE: on start, the block SHALL go to CLEAR (if enabled) or LOAD, clear word_count and error, drive rw=0 and core_reset=1.
REQ-024 CLEAR: imem_we=1, imem_wdata=0, imem_addr 0..2^ADDR_W-1, one per cycle; after the last address the block SHALL enter LOAD.
REQ-025 LOAD: load_ready=1; a handshake is load_valid & load_ready.
REQ-026 A handshake SHALL produce imem_we=1 with the registered address/data exactly one cycle later; the address then increments by 1.
REQ-027 A handshake with load_last=1 SHALL move the block to RELEASE; load_ready SHALL be 0 from the next cycle.
REQ-028 A handshake at address 2^ADDR_W-1 without load_last SHALL set error=1, enter RELEASE, and SHALL NOT wrap the address.
REQ-029 RELEASE: rw=1, core_reset=1 for exactly RELEASE_CYCLES cycles, then RUN.
REQ-030 RUN: core_reset=0, rw=1, done=1, imem_we=0.
REQ-031 start in RUN SHALL restart the load (done=0, core_reset=1, rw=0) in the next cycle; start in any other state SHALL be ignored.
REQ-032 imem_we SHALL never be asserted while rw=1.

Reset
REQ-033 On reset assertion, all outputs SHALL immediately take these values: state IDLE, core_reset=1, rw=0, imem_we=0, imem_addr=0, imem_wdata=0, load_ready=0, busy=0, done=0, error=0, word_count=0.
REQ-034 If reset asserts mid-load, any write that is pending but not yet issued SHALL be dropped.

Configuration
REQ-035 With IMEM_LOAD_CLEAR_EN defined, the CLEAR state SHALL be built and entered after start; without it, start SHALL go directly to LOAD and no CLEAR logic SHALL exist.

Structure
REQ-036 Package imem_ctrl_pkg SHALL hold the state enum, the ADDR_W/DATA_W defaults and the NOP/zero word constant.
REQ-037 Sub-module imem_ld_counter SHALL implement the saturating address/word counter with a wrap-detect output.

Verification
REQ-038 Reset, then start, then words 0x00102083, 0x00250183, 0x003080B3 (last on the third) -> writes to addresses 1, 2 and 3, each one cycle after its handshake; word_count=3; after 2 cycles core_reset=0 and done=1.
REQ-039 load_valid toggling every other cycle -> no duplicated or skipped writes and consecutive addresses.
REQ-040 START_ADDR=1022 with 3 words and no last -> writes to 1022 and 1023, error=1, third word not accepted, block enters RUN.
REQ-041 Reset asserted mid-LOAD after one handshake -> imem_we=0 immediately and the state is IDLE.
REQ-042 start pulse in RUN -> core_reset=1 and rw=0 next cycle, and a second program loads from START_ADDR.
REQ-043 With IMEM_LOAD_CLEAR_EN, ADDR_W=4 -> 16 zero writes before load_ready rises.
